systolic_seq_ctrl: RTL and testbench
====================================

SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 SHALL have parameter SHIFT_CYCLES, default 7: number of cycles shift enables are held per job (legal 1..255).
REQ-002 SHALL have ports `Clock  in  1`: the single clock.
REQ-003 SHALL have `rst_n  in  1`: reset, synchronous, active-low.
REQ-004 SHALL have `start  in  1`: job request, sampled only in IDLE.
REQ-005 SHALL have `abort  in  1`: return to IDLE from any state.
REQ-006 SHALL have `busy  out  1`: state is not IDLE.
REQ-007 SHALL have `done  out  1`: one-cycle pulse at job completion.
REQ-008 SHALL have `in_valid  in  1`, `in_ready  out  1`, `in_data  in  16`: operand stream, 16 B words then 4 A words per job.
REQ-009 SHALL have `external_we  out  1`, `sel_a_or_b  out  1`, `b_sel  out  4`, `a_sel  out  2`, `external_wdata  out  16`: array register-file write port.
REQ-010 SHALL have `data_clear  out  1`, `en_shift_right  out  1`, `en_shift_bottom  out  1`: array controls.
REQ-011 SHALL have `ps_bottom_in  in  64`: array bottom outputs, column k at bits [16k+15:16k].
REQ-012 SHALL have `res_valid  out  1`, `res_ready  in  1`, `res_data  out  64`: result stream.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, LOAD_B, LOAD_A, SHIFT, OUTPUT, DONE, with a 5-bit word/cycle counter cnt.
REQ-014 IDLE: start=1 -> CLEAR; start=0 -> stay; start in any other state SHALL be ignored.
REQ-015 CLEAR: data_clear=1 for exactly one cycle; -> LOAD_B, cnt=0.
REQ-016 LOAD_B: in_ready=1; an accepted word (in_valid & in_ready) SHALL give external_we=1, sel_a_or_b=0, b_sel=cnt[3:0], external_wdata=in_data combinationally in the same cycle; cnt++.
REQ-017 LOAD_B: the acceptance at cnt=15 -> LOAD_A, cnt=0.
REQ-018 LOAD_A: in_ready=1; an accepted word SHALL give external_we=1, sel_a_or_b=1, a_sel=cnt[1:0], external_wdata=in_data.
REQ-019 LOAD_A: the acceptance at cnt=3 -> SHIFT, cnt=0.
REQ-020 Load-state stalls: in_valid=0 SHALL give external_we=0 and leave cnt unchanged.
REQ-021 Outside LOAD_B/LOAD_A: in_ready=0 and external_we=0.
REQ-022 Idle values: sel_a_or_b=0, b_sel=0, a_sel=0, external_wdata=0 whenever not writing.
REQ-023 SHIFT: en_shift_right=en_shift_bottom=1 for exactly SHIFT_CYCLES consecutive cycles; both SHALL be 0 in every other state.
REQ-024 SHIFT: on the last SHIFT cycle, ps_bottom_in SHALL be registered into res_data; -> OUTPUT.
REQ-025 OUTPUT: res_valid=1 with res_data stable until res_ready=1; the handshake cycle -> DONE.
REQ-026 DONE: done=1 for one cycle; -> IDLE.
REQ-027 res_data SHALL hold its value after the handshake until the next capture.
REQ-028 abort=1 in any state SHALL force IDLE on the next edge with cnt=0, and no done pulse.
REQ-029 abort SHALL take priority over start and over all handshakes in the same cycle, including a concurrent input or result handshake.
REQ-030 Zero-stall latency: start at cycle 0 gives CLEAR at 1, LOAD_B at 2-17, LOAD_A at 18-21, SHIFT at 22..21+SHIFT_CYCLES, OUTPUT at 22+SHIFT_CYCLES, and done at 23+SHIFT_CYCLES.
REQ-031 busy SHALL be 1 from the cycle after start is accepted through the DONE cycle inclusive.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE and cnt=0, including mid-job.
REQ-033 rst_n=0 SHALL force busy, done, in_ready, external_we, data_clear, both shift enables, res_valid, sel_a_or_b, b_sel, a_sel, external_wdata and res_data to 0.
REQ-034 Reset SHALL take priority over abort and start.

Verification
REQ-035 Nominal job, SHIFT_CYCLES=7, in_valid always 1, data 0x0001..0x0014, res_ready=1 -> b_sel 0..15 written 0x0001..0x0010, a_sel 0..3 written 0x0011..0x0014, shift enables high cycles 22-28, done at cycle 30.
REQ-036 in_valid deasserted for 3 cycles after word 5 -> no external_we in those cycles; b_sel resumes at 5; done delayed by exactly 3 cycles.
REQ-037 res_ready held 0 for 4 cycles in OUTPUT, ps_bottom_in changed meanwhile -> res_valid stays 1 and res_data equals the value captured on the last SHIFT cycle.
REQ-038 abort in LOAD_A at cnt=2 -> IDLE next cycle, busy=0, no done pulse; a following start runs a full job with CLEAR first.
REQ-039 rst_n=0 for 1 cycle during SHIFT -> all outputs 0 on the next cycle and the FSM in IDLE; start during busy never restarts the job.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a 4x4 systolic array: loads 16 B and 4 A operand words,
// runs the array for SHIFT_CYCLES, and hands the bottom partial sums out on a valid/ready stream.
module systolic_seq_ctrl #(
   parameter int SHIFT_CYCLES = 7
) (
   input  logic        Clock,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        external_we,
   output logic        sel_a_or_b,
   output logic [3:0]  b_sel,
   output logic [1:0]  a_sel,
   output logic [15:0] external_wdata,
   output logic        data_clear,
   output logic        en_shift_right,
   output logic        en_shift_bottom,
   input  logic [63:0] ps_bottom_in,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_data
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD_B,
      LOAD_A,
      SHIFT,
      OUTPUT,
      DONE
   } state_t;

   localparam logic [7:0] SHIFT_LAST = 8'(SHIFT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [4:0]  cnt, cnt_nxt;
   logic [7:0]  shift_cnt, shift_cnt_nxt;
   logic        capture;
   logic [63:0] res_data_p0;

   // state register and result capture
   always_ff @(posedge Clock) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         shift_cnt   <= '0;
         res_data_p0 <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         shift_cnt <= shift_cnt_nxt;
         if (capture) res_data_p0 <= ps_bottom_in;
      end
   end

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      shift_cnt_nxt   = '0;
      capture         = 1'b0;
      busy            = 1'b0;
      done            = 1'b0;
      in_ready        = 1'b0;
      external_we     = 1'b0;
      sel_a_or_b      = 1'b0;
      b_sel           = '0;
      a_sel           = '0;
      external_wdata  = '0;
      data_clear      = 1'b0;
      en_shift_right  = 1'b0;
      en_shift_bottom = 1'b0;
      res_valid       = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            data_clear = 1'b1;
            state_nxt  = LOAD_B;
            cnt_nxt    = '0;
         end
         LOAD_B: begin
            // an abort in the same cycle refuses the word so nothing reaches the array
            in_ready = !abort;
            if (in_valid && !abort) begin
               external_we    = 1'b1;
               b_sel          = cnt[3:0];
               external_wdata = in_data;
               if (cnt == 5'd15) begin
                  state_nxt = LOAD_A;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 5'd1;
               end
            end
         end
         LOAD_A: begin
            in_ready = !abort;
            if (in_valid && !abort) begin
               external_we    = 1'b1;
               sel_a_or_b     = 1'b1;
               a_sel          = cnt[1:0];
               external_wdata = in_data;
               if (cnt == 5'd3) begin
                  state_nxt = SHIFT;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 5'd1;
               end
            end
         end
         SHIFT: begin
            en_shift_right  = 1'b1;
            en_shift_bottom = 1'b1;
            shift_cnt_nxt   = shift_cnt + 8'd1;
            if (shift_cnt == SHIFT_LAST) begin
               capture       = 1'b1;
               shift_cnt_nxt = '0;
               state_nxt     = OUTPUT;
            end
         end
         OUTPUT: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase

      busy = (state != IDLE);

      if (abort) begin
         state_nxt     = IDLE;
         cnt_nxt       = '0;
         shift_cnt_nxt = '0;
         capture       = 1'b0;
      end

      // outputs read as zero for the whole cycle in which reset is asserted
      if (!rst_n) begin
         busy            = 1'b0;
         done            = 1'b0;
         in_ready        = 1'b0;
         external_we     = 1'b0;
         sel_a_or_b      = 1'b0;
         b_sel           = '0;
         a_sel           = '0;
         external_wdata  = '0;
         data_clear      = 1'b0;
         en_shift_right  = 1'b0;
         en_shift_bottom = 1'b0;
         res_valid       = 1'b0;
      end
   end

   assign res_data = rst_n ? res_data_p0 : '0;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: per-cycle schedule of expected outputs
// for nominal, stalled, back-pressured, aborted and reset-interrupted jobs.
module tb_systolic_seq_ctrl;

   localparam int S = 7;

   logic        Clock;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        external_we;
   logic        sel_a_or_b;
   logic [3:0]  b_sel;
   logic [1:0]  a_sel;
   logic [15:0] external_wdata;
   logic        data_clear;
   logic        en_shift_right;
   logic        en_shift_bottom;
   logic [63:0] ps_bottom_in;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_data;

   int checks = 0;
   int errors = 0;
   logic [63:0] prev_res = '0;

   systolic_seq_ctrl #(.SHIFT_CYCLES(S)) dut (
      .Clock          (Clock),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .external_we    (external_we),
      .sel_a_or_b     (sel_a_or_b),
      .b_sel          (b_sel),
      .a_sel          (a_sel),
      .external_wdata (external_wdata),
      .data_clear     (data_clear),
      .en_shift_right (en_shift_right),
      .en_shift_bottom(en_shift_bottom),
      .ps_bottom_in   (ps_bottom_in),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_data       (res_data)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [63:0] pat(input int c);
      logic [15:0] k;
      k = 16'(c);
      return {16'hD000 | k, 16'hC000 | k, 16'hB000 | k, 16'hA000 | k};
   endfunction

   function automatic logic [30:0] obs_vec();
      return {busy, done, in_ready, external_we, data_clear, en_shift_right,
              en_shift_bottom, res_valid, sel_a_or_b, b_sel, a_sel, external_wdata};
   endfunction

   // Cycle 0 is the IDLE cycle in which start is presented.
   task automatic run_job(input string name, input int sw, input int sl, input int hold,
                          input bit start_hold, input int abort_at, input int rst_at);
      int t_le, t_ss, t_se, t_os, t_oe, t_done, c_end, cl, w;
      bit load, stall, wr, killed;
      logic [30:0] exp_v, obs_v;
      logic [63:0] exp_res;
      t_le   = 21 + sl;
      t_ss   = t_le + 1;
      t_se   = t_ss + S - 1;
      t_os   = t_se + 1;
      t_oe   = t_os + hold;
      t_done = t_oe + 1;
      cl     = t_se;
      c_end  = (abort_at >= 0) ? abort_at + 2 : ((rst_at >= 0) ? rst_at + 2 : t_done + 1);
      for (int c = 0; c <= c_end; c++) begin
         load   = (c >= 2) && (c <= t_le);
         stall  = load && (sl > 0) && (c >= 2 + sw) && (c < 2 + sw + sl);
         wr     = load && !stall;
         w      = (sl == 0 || c < 2 + sw) ? c - 2 : c - 2 - sl;
         killed = (abort_at >= 0 && c > abort_at) || (rst_at >= 0 && c >= rst_at);
         @(posedge Clock);
         #1;
         start        = (c == 0) || (start_hold && c < t_done && !killed);
         abort        = (c == abort_at);
         rst_n        = (c != rst_at);
         in_valid     = !stall;
         in_data      = wr ? 16'(w + 1) : 16'hDEAD;
         res_ready    = !(c >= t_os && c < t_os + hold);
         ps_bottom_in = pat(c);
         @(negedge Clock);
         if (c == abort_at) continue;
         if (killed) begin
            exp_v = '0;
         end else begin
            exp_v = {(c >= 1 && c <= t_done), (c == t_done), load, wr, (c == 1),
                     (c >= t_ss && c <= t_se), (c >= t_ss && c <= t_se),
                     (c >= t_os && c <= t_oe), (wr && w >= 16),
                     (wr && w < 16) ? 4'(w) : 4'd0,
                     (wr && w >= 16) ? 2'(w - 16) : 2'd0,
                     wr ? 16'(w + 1) : 16'd0};
         end
         if (rst_at >= 0 && c >= rst_at) prev_res = '0;
         exp_res = (!killed && c > cl) ? pat(cl) : prev_res;
         obs_v = obs_vec();
         checks++;
         assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s c%0d ctrl observed=%h expected=%h", name, c, obs_v, exp_v);
         end
         checks++;
         assert (res_data === exp_res) else begin
            errors++;
            $error("FAIL %s c%0d res_data observed=%h expected=%h", name, c, res_data, exp_res);
         end
      end
      if (abort_at < 0 && rst_at < 0) prev_res = pat(cl);
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n        = 1'b0;
      start        = 1'b1;
      abort        = 1'b1;
      in_valid     = 1'b1;
      in_data      = 16'h1234;
      res_ready    = 1'b1;
      ps_bottom_in = 64'hFFFF_0000_FFFF_0000;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      checks++;
      assert (obs_vec() === 31'd0) else begin
         errors++;
         $error("FAIL reset ctrl observed=%h expected=%h", obs_vec(), 31'd0);
      end
      checks++;
      assert (res_data === 64'd0) else begin
         errors++;
         $error("FAIL reset res_data observed=%h expected=%h", res_data, 64'd0);
      end
      @(posedge Clock);
      #1;
      rst_n = 1'b1;
      start = 1'b0;
      abort = 1'b0;

      run_job("nominal", 0, 0, 0, 1'b0, -1, -1);
      run_job("stall",   5, 3, 0, 1'b0, -1, -1);
      run_job("hold",    0, 0, 4, 1'b1, -1, -1);
      run_job("abort",   0, 0, 0, 1'b0, 20, -1);
      run_job("rerun",   0, 0, 0, 1'b0, -1, -1);
      run_job("rst_mid", 0, 0, 0, 1'b1, -1, 24);
      run_job("recover", 0, 0, 2, 1'b0, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
